// File: rtl/xentry_pkg.sv
// Shared types for the L2 request handshake: memory operation encoding and
// the responder state encoding.
package xentry_pkg;

   typedef enum logic [1:0] {
      MO_LOAD    = 2'b00,
      MO_STORE   = 2'b01,
      MO_CLFLUSH = 2'b10,
      MO_UNKNOWN = 2'b11
   } memory_operation_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_BUSY    = 2'b01,
      ST_RESPOND = 2'b10,
      ST_UNKNOWN = 2'b11
   } l2_responder_state_e;

   localparam int L2_DEFAULT_RESP_LATENCY = 4;

   // An X or MO_UNKNOWN type falls through to the default and is rejected.
   function automatic logic is_legal_op(input memory_operation_e op);
      case (op)
         MO_LOAD, MO_STORE, MO_CLFLUSH: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/l2_word_ram.sv
// Single-port word RAM: synchronous write, registered read with one cycle
// of latency; the read register holds its value between reads.
module l2_word_ram #(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic                         re,
   input  logic [$clog2(MEM_WORDS)-1:0] addr,
   input  logic [XLEN-1:0]              wdata,
   output logic [XLEN-1:0]              rdata
);

   logic [XLEN-1:0] mem [MEM_WORDS];
   logic [XLEN-1:0] rdata_q, rdata_d;

   // NOTE: the array has no reset so it maps onto block RAM; only the read
   // register is reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/l2_responder.sv
// Memory-side responder for the L2 req_valid/req_fulfilled handshake with a
// fixed response latency. Optional counters: L2_RESPONDER_COUNTERS_EN.
module l2_responder
   import xentry_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int MEM_WORDS    = 1024,
   parameter int RESP_LATENCY = L2_DEFAULT_RESP_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  memory_operation_e req_type,
   input  logic [XLEN-1:0]   req_address,
   input  logic [XLEN-1:0]   req_store_word,
   output logic              req_fulfilled,
   output logic [XLEN-1:0]   req_loaded_word,
   output logic              protocol_error
`ifdef L2_RESPONDER_COUNTERS_EN
   ,
   output logic [XLEN-1:0]   load_count,
   output logic [XLEN-1:0]   store_count,
   output logic [XLEN-1:0]   flush_count
`endif
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

   l2_responder_state_e state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   memory_operation_e   op_q, op_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic                err_q, err_d;
   logic                ram_we, ram_re;

   // Byte-offset bits and address bits above the RAM depth alias away.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_address[XLEN-1:IDX_W+2], req_address[1:0]};

   // NOTE: every signal gets its default first so no path leaves one
   // unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      ram_re  = 1'b0;
      ram_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (is_legal_op(req_type)) begin
                  op_d    = req_type;
                  idx_d   = req_address[IDX_W+1:2];
                  wdata_d = req_store_word;
                  cnt_d   = CNT_W'(RESP_LATENCY - 1);
                  state_d = ST_BUSY;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               // Read issued here so the registered data lands in RESPOND.
               ram_re  = (op_q == MO_LOAD);
               state_d = ST_RESPOND;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESPOND: begin
            ram_we  = (op_q == MO_STORE);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MO_LOAD;
         idx_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   l2_word_ram #(
      .XLEN      (XLEN),
      .MEM_WORDS (MEM_WORDS)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (req_loaded_word)
   );

   assign req_fulfilled  = (state_q == ST_RESPOND);
   assign protocol_error = err_q;

`ifdef L2_RESPONDER_COUNTERS_EN
   logic [XLEN-1:0] load_cnt_q, load_cnt_d;
   logic [XLEN-1:0] store_cnt_q, store_cnt_d;
   logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      load_cnt_d  = load_cnt_q;
      store_cnt_d = store_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == ST_RESPOND) begin
         case (op_q)
            MO_LOAD:    if (load_cnt_q != '1)  load_cnt_d  = load_cnt_q + 1'b1;
            MO_STORE:   if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
            MO_CLFLUSH: if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         load_cnt_q  <= load_cnt_d;
         store_cnt_q <= store_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign load_count  = load_cnt_q;
   assign store_count = store_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder: latency, line fill, aliasing, commit,
// abort, flush and protocol error; counters when L2_RESPONDER_COUNTERS_EN.
module tb_l2_responder;
   import xentry_pkg::*;

   localparam int XLEN = 32;
   localparam int LAT  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   memory_operation_e req_type;
   logic [XLEN-1:0]   req_address;
   logic [XLEN-1:0]   req_store_word;
   logic              req_fulfilled;
   logic [XLEN-1:0]   req_loaded_word;
   logic              protocol_error;
`ifdef L2_RESPONDER_COUNTERS_EN
   logic [XLEN-1:0]   load_count, store_count, flush_count;
`endif

   l2_responder #(
      .XLEN         (XLEN),
      .MEM_WORDS    (1024),
      .RESP_LATENCY (LAT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_type        (req_type),
      .req_address     (req_address),
      .req_store_word  (req_store_word),
      .req_fulfilled   (req_fulfilled),
      .req_loaded_word (req_loaded_word),
      .protocol_error  (protocol_error)
`ifdef L2_RESPONDER_COUNTERS_EN
      ,
      .load_count      (load_count),
      .store_count     (store_count),
      .flush_count     (flush_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses = 0;
   int m_load = 0, m_store = 0, m_flush = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && req_fulfilled) pulses <= pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Drives one request and waits (bounded) for its pulse; valid is dropped
   // at the pulse unless hold is set.
   task automatic xfer(input memory_operation_e op, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold,
                       output logic [31:0] rd, output int lat, output int pcyc);
      @(negedge clk);
      req_valid      = 1'b1;
      req_type       = op;
      req_address    = addr;
      req_store_word = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!req_fulfilled && lat < 30);
      rd   = req_loaded_word;
      pcyc = cyc;
      if (req_fulfilled) begin
         case (op)
            MO_LOAD:    m_load++;
            MO_STORE:   m_store++;
            MO_CLFLUSH: m_flush++;
            default: ;
         endcase
      end
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic op1(input string tag, input memory_operation_e op,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
      int lat, pc;
      xfer(op, addr, wd, 1'b0, rd, lat, pc);
      check({tag, "_lat"}, lat, LAT + 1);
   endtask

   initial begin
      logic [31:0] rd;
      int lat, pc, prev_pc, p0, waited;

      reset = 1'b1;
      req_valid = 1'b0;
      req_type = MO_LOAD;
      req_address = '0;
      req_store_word = '0;
      repeat (3) @(negedge clk);
      check("rst_fulfilled", {31'b0, req_fulfilled}, 32'h0);
      check("rst_loaded", req_loaded_word, 32'h0);
      check("rst_perr", {31'b0, protocol_error}, 32'h0);
      reset = 1'b0;

      p0 = pulses;
      repeat (20) @(negedge clk);
      check("idle_pulses", pulses - p0, 0);
      check("idle_perr", {31'b0, protocol_error}, 32'h0);

      op1("st40", MO_STORE, 32'h40, 32'hDEADBEEF, rd);
      op1("ld40", MO_LOAD, 32'h40, 32'h0, rd);
      check("ld40_data", rd, 32'hDEADBEEF);

      for (int i = 0; i < 4; i++) op1("st_line", MO_STORE, 32'h100 + 4 * i, i + 1, rd);
      prev_pc = 0;
      for (int i = 0; i < 4; i++) begin
         xfer(MO_LOAD, 32'h100 + 4 * i, 32'h0, (i < 3), rd, lat, pc);
         check("fill_data", rd, i + 1);
         if (i == 0) check("fill_lat", lat, LAT + 1);
         else        check("fill_spacing", pc - prev_pc, LAT + 2);
         prev_pc = pc;
      end

      op1("st300", MO_STORE, 32'h300, 32'h99, rd);
      check("hold_loaded", rd, 32'h4);

      op1("st0", MO_STORE, 32'h0, 32'hA5, rd);
      op1("ld1000", MO_LOAD, 32'h1000, 32'h0, rd);
      check("alias_1000", rd, 32'hA5);
      op1("ld3", MO_LOAD, 32'h3, 32'h0, rd);
      check("alias_3", rd, 32'hA5);

      @(negedge clk);
      req_valid = 1'b1; req_type = MO_STORE; req_address = 32'h204; req_store_word = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      waited = 0;
      while (!req_fulfilled && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("commit_pulse", {31'b0, req_fulfilled}, 32'h1);
      if (req_fulfilled) m_store++;
      op1("ld204", MO_LOAD, 32'h204, 32'h0, rd);
      check("commit_data", rd, 32'h77);

      op1("fl40", MO_CLFLUSH, 32'h40, 32'h0, rd);
      op1("ld40b", MO_LOAD, 32'h40, 32'h0, rd);
      check("flush_keeps", rd, 32'hDEADBEEF);

      op1("st80", MO_STORE, 32'h80, 32'h11, rd);
      @(negedge clk);
      req_valid = 1'b1; req_type = MO_STORE; req_address = 32'h80; req_store_word = 32'h55;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      req_valid = 1'b0;
      m_load = 0; m_store = 0; m_flush = 0;
      p0 = pulses;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_pulses", pulses - p0, 0);
      check("abort_loaded", req_loaded_word, 32'h0);
      op1("ld80", MO_LOAD, 32'h80, 32'h0, rd);
      check("abort_data", rd, 32'h11);

      @(negedge clk);
      req_valid = 1'b1; req_type = MO_UNKNOWN; req_address = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      p0 = pulses;
      check("perr_set", {31'b0, protocol_error}, 32'h1);
      repeat (8) @(negedge clk);
      check("perr_no_pulse", pulses - p0, 0);
      op1("ld40c", MO_LOAD, 32'h40, 32'h0, rd);
      check("perr_ld_data", rd, 32'hDEADBEEF);
      check("perr_sticky", {31'b0, protocol_error}, 32'h1);

      op1("st84", MO_STORE, 32'h84, 32'h22, rd);
      op1("st88", MO_STORE, 32'h88, 32'h33, rd);
      op1("ld84", MO_LOAD, 32'h84, 32'h0, rd);
      check("ld84_data", rd, 32'h22);
      op1("fl88", MO_CLFLUSH, 32'h88, 32'h0, rd);
      op1("ld88", MO_LOAD, 32'h88, 32'h0, rd);
      check("flush88_keeps", rd, 32'h33);

`ifdef L2_RESPONDER_COUNTERS_EN
      @(negedge clk);
      check("cnt_load", load_count, m_load);
      check("cnt_store", store_count, m_store);
      check("cnt_flush", flush_count, m_flush);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
